phase_detect: RTL and testbench

PHASE_DETECT -- requirements
Module: phase_detect

---
 rtl/phase_detect.sv | 140 ++++++++++++++
 tb/tb_phase_detect.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_detect.sv
// Phase/frequency detector: synchronizes the asynchronous ref and fb pulses and
// measures the signed distance between their rising edges in sys_clk cycles.
module phase_detect #(
  parameter int WIDTH_ERR = 22,
  parameter int SYNC      = 2
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        ref_in,
  input  logic                        fb_in,
  output logic signed [WIDTH_ERR-1:0] err,
  output logic                        process,
  output logic                        sat,
  output logic                        slip
);

  typedef enum logic [1:0] {IDLE, WAIT_FB, WAIT_REF} state_t;

  localparam logic signed [WIDTH_ERR-1:0] LIM     = {1'b0, {(WIDTH_ERR-1){1'b1}}};
  localparam logic signed [WIDTH_ERR-1:0] NEG_LIM = -LIM;
  localparam logic signed [WIDTH_ERR-1:0] ONE     = {{(WIDTH_ERR-1){1'b0}}, 1'b1};
  localparam logic signed [WIDTH_ERR-1:0] NEG_ONE = '1;

  if (SYNC < 2) begin : g_sync_check
    $error("phase_detect: SYNC must be at least 2");
  end

  logic [SYNC-1:0] ref_sync, fb_sync;
  logic            ref_d, fb_d;
  logic            ref_rise, fb_rise;

  // Synchronizers and edge registers ignore enable so that re-enabling with an
  // input already high never manufactures an edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_d    <= 1'b0;
      fb_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // so the shift chain moves exactly one stage per clock regardless of order.
      ref_sync <= {ref_sync[SYNC-2:0], ref_in};
      fb_sync  <= {fb_sync[SYNC-2:0], fb_in};
      ref_d    <= ref_sync[SYNC-1];
      fb_d     <= fb_sync[SYNC-1];
    end
  end

  assign ref_rise = ref_sync[SYNC-1] & ~ref_d;
  assign fb_rise  = fb_sync[SYNC-1] & ~fb_d;

  state_t                      state;
  logic signed [WIDTH_ERR-1:0] cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      err     <= '0;
      process <= 1'b0;
      sat     <= 1'b0;
      slip    <= 1'b0;
    end else begin
      process <= 1'b0;
      sat     <= 1'b0;
      slip    <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        err   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (ref_rise && fb_rise) begin
              err     <= '0;
              process <= 1'b1;
            end else if (ref_rise) begin
              state <= WAIT_FB;
              cnt   <= ONE;
            end else if (fb_rise) begin
              state <= WAIT_REF;
              cnt   <= NEG_ONE;
            end
          end
          WAIT_FB: begin
            // The closing edge reports cnt as it stood before this cycle's step.
            if (fb_rise) begin
              err     <= cnt;
              process <= 1'b1;
              sat     <= (cnt == LIM);
              if (ref_rise) begin
                slip <= 1'b1;
                cnt  <= ONE;
              end else begin
                state <= IDLE;
              end
            end else if (ref_rise) begin
              slip <= 1'b1;
              cnt  <= ONE;
            end else if (cnt == LIM) begin
              err     <= LIM;
              process <= 1'b1;
              sat     <= 1'b1;
              state   <= IDLE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          WAIT_REF: begin
            if (ref_rise) begin
              err     <= cnt;
              process <= 1'b1;
              sat     <= (cnt == NEG_LIM);
              if (fb_rise) begin
                slip <= 1'b1;
                cnt  <= NEG_ONE;
              end else begin
                state <= IDLE;
              end
            end else if (fb_rise) begin
              slip <= 1'b1;
              cnt  <= NEG_ONE;
            end else if (cnt == NEG_LIM) begin
              err     <= NEG_LIM;
              process <= 1'b1;
              sat     <= 1'b1;
              state   <= IDLE;
            end else begin
              cnt <= cnt - ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_detect.sv
// Self-checking bench for phase_detect: table-driven edge pairs scored through a
// queue, plus hand-written slip, saturation, reset-abort and enable sequences.
module tb_phase_detect;

  localparam int W = 22;

  logic                sys_clk = 1'b0;
  logic                rst_n, enable, ref_in, fb_in;
  logic signed [W-1:0] err;
  logic                process, sat, slip;
  logic signed [7:0]   err8;
  logic                proc8, sat8, slip8;

  phase_detect dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .ref_in(ref_in), .fb_in(fb_in),
    .err(err), .process(process), .sat(sat), .slip(slip)
  );

  phase_detect #(.WIDTH_ERR(8)) dut8 (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .ref_in(ref_in), .fb_in(fb_in),
    .err(err8), .process(proc8), .sat(sat8), .slip(slip8)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic signed [W-1:0] err;
    logic                sat;
  } exp_t;

  typedef struct {
    int                  lead;  // cycles ref leads fb; negative means fb leads
    logic signed [W-1:0] err;
    logic                sat;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur;
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   proc_cnt = 0;
  int   slip_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic signed [W-1:0] e, input logic s);
    exp_t x;
    x.err = e;
    x.sat = s;
    exp_q.push_back(x);
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge sys_clk) begin
    if (slip) slip_cnt++;
    if (process) begin
      proc_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_process: got strobe with err=%0d, required none", err);
      end else begin
        cur = exp_q.pop_front();
        check("err", err, cur.err);
        check("sat", sat, cur.sat);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_timeout: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic run_edges(input int lead, input logic signed [W-1:0] e, input logic s);
    if (lead > 0) begin
      ref_in = 1'b1;
      repeat (lead) @(negedge sys_clk);
      fb_in = 1'b1;
    end else if (lead < 0) begin
      fb_in = 1'b1;
      repeat (-lead) @(negedge sys_clk);
      ref_in = 1'b1;
    end else begin
      ref_in = 1'b1;
      fb_in  = 1'b1;
    end
    push(e, s);
    repeat (3) @(negedge sys_clk);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    drain();
  endtask

  initial begin
    int k, lat, sb, pb;
    logic got;
    logic signed [7:0] e8;
    logic s8;

    vecs[0] = '{lead:   5, err: 22'sd5,    sat: 1'b0};
    vecs[1] = '{lead: -12, err: 22'h3FFFF4, sat: 1'b0};
    vecs[2] = '{lead:   0, err: 22'sd0,    sat: 1'b0};
    vecs[3] = '{lead:   1, err: 22'sd1,    sat: 1'b0};
    vecs[4] = '{lead:  -1, err: -22'sd1,   sat: 1'b0};
    vecs[5] = '{lead:   7, err: 22'sd7,    sat: 1'b0};
    vecs[6] = '{lead: -30, err: -22'sd30,  sat: 1'b0};
    vecs[7] = '{lead:   2, err: 22'sd2,    sat: 1'b0};

    // NOTE: inputs are driven with blocking assignments on the falling edge so the
    // DUT sees them settled well before the next rising edge.
    rst_n  = 1'b0;
    enable = 1'b1;
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("reset_err", err, 0);
    check("reset_process", process, 0);
    check("reset_sat", sat, 0);
    check("reset_slip", slip, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    sb = slip_cnt;
    for (int i = 0; i < 8; i++) run_edges(vecs[i].lead, vecs[i].err, vecs[i].sat);
    check("table_no_slip", slip_cnt - sb, 0);

    // Latency: strobe SYNC+1 cycles after the closing fb edge.
    ref_in = 1'b1;
    repeat (5) @(negedge sys_clk);
    fb_in = 1'b1;
    push(22'sd5, 1'b0);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge sys_clk);
      if (process && lat == 0) lat = i;
    end
    check("latency", lat, 3);
    drain();

    // Repeated ref edge is a slip and re-arms the count.
    ref_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    ref_in = 1'b0;
    repeat (17) @(negedge sys_clk);
    ref_in = 1'b1;
    sb = slip_cnt;
    repeat (3) @(negedge sys_clk);
    fb_in = 1'b1;
    push(22'sd3, 1'b0);
    repeat (3) @(negedge sys_clk);
    drain();
    check("slip_count", slip_cnt - sb, 1);

    // 8-bit instance saturates at +127; the 22-bit instance keeps counting.
    ref_in = 1'b1;
    k = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      @(negedge sys_clk);
      k++;
      if (k == 3) ref_in = 1'b0;
      if (proc8) got = 1'b1;
    end
    check("sat8_seen", got, 1);
    check("sat8_latency", k, 130);
    check("sat8_err", err8, 127);
    check("sat8_flag", sat8, 1);
    @(negedge sys_clk);
    k++;
    check("sat8_one_cycle", {proc8, sat8}, 0);
    repeat (9) @(negedge sys_clk);
    k += 9;
    fb_in = 1'b1;
    push(W'(k), 1'b0);
    repeat (2) @(negedge sys_clk);
    fb_in = 1'b0;
    repeat (2) @(negedge sys_clk);
    ref_in = 1'b1;
    got = 1'b0;
    e8 = '0;
    s8 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge sys_clk);
      if (proc8 && !got) begin
        got = 1'b1;
        e8 = err8;
        s8 = sat8;
      end
    end
    check("wait_ref8_seen", got, 1);
    check("wait_ref8_err", e8, -4);
    check("wait_ref8_sat", s8, 0);
    ref_in = 1'b0;
    repeat (2) @(negedge sys_clk);
    fb_in = 1'b1;
    push(22'sd8, 1'b0);
    repeat (3) @(negedge sys_clk);
    drain();

    // Reset mid-measurement: no strobe, outputs cleared, then fb opens WAIT_REF.
    ref_in = 1'b1;
    repeat (7) @(negedge sys_clk);
    ref_in = 1'b0;
    @(negedge sys_clk);
    pb = proc_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("abort_err", err, 0);
    check("abort_process", process, 0);
    check("abort_sat", sat, 0);
    check("abort_slip", slip, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    fb_in = 1'b1;
    repeat (15) @(negedge sys_clk);
    check("abort_no_strobe", proc_cnt - pb, 0);
    ref_in = 1'b1;
    push(-22'sd15, 1'b0);
    repeat (3) @(negedge sys_clk);
    drain();

    // enable low clears outputs; inputs already high at re-enable are not edges.
    ref_in = 1'b1;
    repeat (6) @(negedge sys_clk);
    enable = 1'b0;
    @(negedge sys_clk);
    check("disable_err", err, 0);
    check("disable_process", process, 0);
    fb_in = 1'b1;
    repeat (5) @(negedge sys_clk);
    enable = 1'b1;
    pb = proc_cnt;
    repeat (10) @(negedge sys_clk);
    check("reenable_no_edge", proc_cnt - pb, 0);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (5) @(negedge sys_clk);
    run_edges(4, 22'sd4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
